// File: rtl/pwm_dac_multi_if.sv
// Control and status bundle for the multi-channel PWM / sigma-delta DAC.
// The master side drives writes and enable; the slave side is the DAC core.
interface pwm_dac_multi_if #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 2
);
  logic                en;
  logic                wr_en;
  logic [2:0]          wr_ch;
  logic [WIDTH-1:0]    wr_data;
  logic                mode_in;
  logic [CHANNELS-1:0] dac_out;
  logic [CHANNELS-1:0] pending;
  logic                period_tick;
  logic                mode_active;

  modport master (
    output en, wr_en, wr_ch, wr_data, mode_in,
    input  dac_out, pending, period_tick, mode_active
  );

  modport slave (
    input  en, wr_en, wr_ch, wr_data, mode_in,
    output dac_out, pending, period_tick, mode_active
  );
endinterface

// File: rtl/pwm_dac_multi.sv
// Multi-channel 1-bit DAC: PWM against a shared counter or first-order sigma-delta,
// with double-buffered codes and mode that commit only on the period boundary.
module pwm_dac_multi #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 2
) (
  input logic             clk,
  input logic             rst,
  pwm_dac_multi_if.slave  bus
);

  logic [WIDTH-1:0]    cnt_p0;
  logic [WIDTH-1:0]    shadow [CHANNELS];
  logic [WIDTH-1:0]    active [CHANNELS];
  logic [WIDTH-1:0]    acc    [CHANNELS];
  logic [WIDTH:0]      sum    [CHANNELS];
  logic [CHANNELS-1:0] dac_p1;
  logic [CHANNELS-1:0] pending_q;
  logic                tick_p1;
  logic                mode_shadow;
  logic                mode_active_q;
  logic                commit;

  function automatic logic [WIDTH:0] sd_sum(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] code);
    return {1'b0, a} + {1'b0, code};
  endfunction

  assign commit = bus.en && (cnt_p0 == {WIDTH{1'b1}});

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i] = sd_sum(acc[i], active[i]);
    end
  end

  // Stage p0 -> p1: counter/accumulator state to registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0        <= '0;
      dac_p1        <= '0;
      pending_q     <= '0;
      tick_p1       <= 1'b0;
      mode_shadow   <= 1'b0;
      mode_active_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
        acc[i]    <= '0;
      end
    end else begin
      mode_shadow <= bus.mode_in;
      tick_p1     <= commit;
      if (bus.en) cnt_p0 <= cnt_p0 + WIDTH'(1);
      if (commit) begin
        mode_active_q <= mode_shadow;
        pending_q     <= '0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        // Commit reads the pre-write shadow; a same-cycle write re-arms pending.
        if (commit) active[i] <= shadow[i];
        if (bus.wr_en && (bus.wr_ch == 3'(i))) begin
          shadow[i]    <= bus.wr_data;
          pending_q[i] <= 1'b1;
        end
        if (commit && (mode_shadow != mode_active_q)) acc[i] <= '0;
        else if (bus.en && mode_active_q)            acc[i] <= sum[i][WIDTH-1:0];
        if (!bus.en)            dac_p1[i] <= 1'b0;
        else if (mode_active_q) dac_p1[i] <= sum[i][WIDTH];
        else                    dac_p1[i] <= (cnt_p0 < active[i]);
      end
    end
  end

  assign bus.dac_out     = dac_p1;
  assign bus.pending     = pending_q;
  assign bus.period_tick = tick_p1;
  assign bus.mode_active = mode_active_q;

endmodule

// File: tb/tb_pwm_dac_multi.sv
// Directed bench for pwm_dac_multi: a WIDTH=4/CHANNELS=2 instance for the
// functional vectors and a WIDTH=12/CHANNELS=4 instance for mid-period async reset.
module tb_pwm_dac_multi;

  logic clk = 1'b0;
  logic rst_s;
  logic rst_b;
  always #5 clk = ~clk;

  pwm_dac_multi_if #(.WIDTH(4),  .CHANNELS(2)) s_if ();
  pwm_dac_multi_if #(.WIDTH(12), .CHANNELS(4)) b_if ();

  pwm_dac_multi #(.WIDTH(4), .CHANNELS(2)) dut_s (
    .clk (clk),
    .rst (rst_s),
    .bus (s_if.slave)
  );

  pwm_dac_multi #(.WIDTH(12), .CHANNELS(4)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (b_if.slave)
  );

  typedef struct {
    logic       en;
    logic       wr_en;
    logic [2:0] ch;
    logic [3:0] data;
    logic       mode_in;
    int         gap;
    logic [1:0] dac;
    logic [1:0] pend;
    logic       tick;
    logic       mode;
  } vec_t;

  vec_t tbl [12];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic en, input logic wr_en, input logic [2:0] ch,
                              input logic [3:0] data, input logic mode_in, input int gap,
                              input logic [1:0] dac, input logic [1:0] pend,
                              input logic tick, input logic mode);
    vec_t v;
    v.en = en; v.wr_en = wr_en; v.ch = ch; v.data = data; v.mode_in = mode_in;
    v.gap = gap; v.dac = dac; v.pend = pend; v.tick = tick; v.mode = mode;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input int idx);
    vec_t v;
    v = tbl[idx];
    s_if.en      = v.en;
    s_if.mode_in = v.mode_in;
    s_if.wr_en   = 1'b0;
    repeat (v.gap) cyc();
    s_if.wr_en   = v.wr_en;
    s_if.wr_ch   = v.ch;
    s_if.wr_data = v.data;
    cyc();
    s_if.wr_en   = 1'b0;
    chk($sformatf("vec%0d_dac", idx),  s_if.dac_out,     v.dac);
    chk($sformatf("vec%0d_pend", idx), s_if.pending,     v.pend);
    chk($sformatf("vec%0d_tick", idx), s_if.period_tick, v.tick);
    chk($sformatf("vec%0d_mode", idx), s_if.mode_active, v.mode);
  endtask

  // Walk counter values start..15; pattern bit k is the expected output after the edge at counter k.
  task automatic check_period(input int start, input logic [15:0] p0, input logic [15:0] p1,
                              input logic [1:0] pm, input logic [1:0] pe,
                              input logic mm, input logic me);
    s_if.en    = 1'b1;
    s_if.wr_en = 1'b0;
    for (int k = start; k < 16; k++) begin
      cyc();
      chk($sformatf("per_dac_k%0d", k),  s_if.dac_out,     {p1[k], p0[k]});
      chk($sformatf("per_tick_k%0d", k), s_if.period_tick, (k == 15));
      chk($sformatf("per_pend_k%0d", k), s_if.pending,     (k == 15) ? pe : pm);
      chk($sformatf("per_mode_k%0d", k), s_if.mode_active, (k == 15) ? me : mm);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_tick;
    logic [3:0] dac_or;

    // en wr ch data mode gap | dac pend tick mode
    tbl[0]  = mk(1, 1, 0,  5, 0,  0, 2'b00, 2'b01, 0, 0);
    tbl[1]  = mk(1, 1, 1, 15, 0,  0, 2'b00, 2'b11, 0, 0);
    tbl[2]  = mk(1, 1, 5,  9, 0,  0, 2'b00, 2'b11, 0, 0);
    tbl[3]  = mk(1, 0, 0,  0, 0, 12, 2'b00, 2'b00, 1, 0);
    tbl[4]  = mk(1, 1, 0,  2, 0,  0, 2'b11, 2'b01, 0, 0);
    tbl[5]  = mk(1, 1, 0,  7, 0, 14, 2'b00, 2'b01, 1, 0);
    tbl[6]  = mk(1, 0, 0,  0, 1,  0, 2'b11, 2'b00, 0, 0);
    tbl[7]  = mk(1, 0, 0,  0, 1,  0, 2'b11, 2'b00, 0, 0);
    tbl[8]  = mk(1, 0, 0,  0, 1,  0, 2'b11, 2'b00, 0, 0);
    tbl[9]  = mk(0, 1, 0,  3, 1,  0, 2'b00, 2'b01, 0, 0);
    tbl[10] = mk(0, 1, 1,  8, 1,  0, 2'b00, 2'b11, 0, 0);
    tbl[11] = mk(0, 0, 0,  0, 1,  7, 2'b00, 2'b11, 0, 0);

    rst_s = 1'b1; rst_b = 1'b1;
    s_if.en = 1'b0; s_if.wr_en = 1'b0; s_if.wr_ch = '0; s_if.wr_data = '0; s_if.mode_in = 1'b0;
    b_if.en = 1'b0; b_if.wr_en = 1'b0; b_if.wr_ch = '0; b_if.wr_data = '0; b_if.mode_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s_dac",  s_if.dac_out,     0);
    chk("rst_s_pend", s_if.pending,     0);
    chk("rst_s_tick", s_if.period_tick, 0);
    chk("rst_s_mode", s_if.mode_active, 0);
    chk("rst_b_dac",  b_if.dac_out,     0);
    chk("rst_b_pend", b_if.pending,     0);
    rst_s = 1'b0; rst_b = 1'b0;

    // Idle: ticks after the 16th and 32nd enabled edge, outputs stay low
    s_if.en = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      cyc();
      chk($sformatf("idle_tick_n%0d", n), s_if.period_tick, (n % 16) == 0);
      chk($sformatf("idle_dac_n%0d", n),  s_if.dac_out,     0);
      chk($sformatf("idle_pend_n%0d", n), s_if.pending,     0);
    end

    // PWM duty ch0=5, ch1=15 plus an ignored write to channel 5
    for (int i = 0; i <= 3; i++) apply(i);
    check_period(0, 16'h001F, 16'h7FFF, 2'b00, 2'b00, 1'b0, 1'b0);
    check_period(0, 16'h001F, 16'h7FFF, 2'b00, 2'b00, 1'b0, 1'b0);

    // Write landing on the commit edge: 2 commits now, 7 one period later
    for (int i = 4; i <= 5; i++) apply(i);
    check_period(0, 16'h0003, 16'h7FFF, 2'b01, 2'b00, 1'b0, 1'b0);
    check_period(0, 16'h007F, 16'h7FFF, 2'b00, 2'b00, 1'b0, 1'b0);

    // Enable gating mid-period with writes while disabled, then resume at counter 3
    for (int i = 6; i <= 11; i++) apply(i);
    check_period(3, 16'h007F, 16'h7FFF, 2'b11, 2'b00, 1'b0, 1'b1);

    // Sigma-delta: code 3 -> ones at 5,10,15; code 8 -> alternating
    check_period(0, 16'h8420, 16'hAAAA, 2'b00, 2'b00, 1'b1, 1'b1);
    check_period(0, 16'h8420, 16'hAAAA, 2'b00, 2'b00, 1'b1, 1'b1);
    s_if.en = 1'b0;

    // Wide instance: commit codes, run to counter 1000, async reset between edges
    b_if.wr_en = 1'b1; b_if.wr_ch = 3'd0; b_if.wr_data = 12'd2000;
    cyc();
    chk("big_pend_w0", b_if.pending, 4'b0001);
    b_if.wr_ch = 3'd3; b_if.wr_data = 12'd4095;
    cyc();
    chk("big_pend_w3", b_if.pending, 4'b1001);
    b_if.wr_en = 1'b0;
    b_if.en = 1'b1;
    repeat (4096) cyc();
    chk("big_commit_tick", b_if.period_tick, 1);
    chk("big_commit_pend", b_if.pending, 0);
    repeat (999) cyc();
    b_if.wr_en = 1'b1; b_if.wr_ch = 3'd1; b_if.wr_data = 12'd5;
    cyc();
    b_if.wr_en = 1'b0;
    chk("big_dac_c999", b_if.dac_out, 4'b1001);
    chk("big_pend_c999", b_if.pending, 4'b0010);
    #2 rst_b = 1'b1;
    #1;
    chk("big_async_dac",  b_if.dac_out,     0);
    chk("big_async_pend", b_if.pending,     0);
    chk("big_async_tick", b_if.period_tick, 0);
    chk("big_async_mode", b_if.mode_active, 0);
    #1 rst_b = 1'b0;

    first_tick = -1;
    dac_or = '0;
    for (int n = 1; n <= 5000; n++) begin
      cyc();
      dac_or = dac_or | b_if.dac_out;
      if (b_if.period_tick && first_tick < 0) first_tick = n;
      if (first_tick >= 0) break;
    end
    chk("big_restart_tick_edge", first_tick, 4096);
    chk("big_restart_dac", dac_or, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_dac_multi.md
Name: pwm_dac_multi

Overview:
- Parametrised, multi-channel successor to the single 12-bit PWM DAC.
- Each channel generates a 1-bit density-modulated output in one of two modes: classic PWM (compare against a shared counter) or first-order sigma-delta (carry of a phase accumulator).
- Channel codes and mode are double-buffered: writes land in shadow registers and commit only at the period boundary, so outputs never glitch mid-period.
- Sits between the pin-level input muxing and the uo_out pads of the top-level wrapper.

Parameters:
- WIDTH, 12, resolution in bits of each channel code and of the shared period counter (period = 2^WIDTH cycles).
- CHANNELS, 2, number of independent DAC outputs (1..8).

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run enable; low freezes the counter and accumulators.
- wr_en  input  1  write strobe for a channel shadow register.
- wr_ch  input  3  channel index for the write.
- wr_data  input  WIDTH  code to write.
- mode_in  input  1  requested mode: 0 = PWM, 1 = sigma-delta; shadowed like codes.
- dac_out  output  CHANNELS  registered 1-bit DAC outputs, bit i = channel i.
- pending  output  CHANNELS  bit i high while channel i's shadow holds an uncommitted write.
- period_tick  output  1  one-cycle pulse marking the start of a period.
- mode_active  output  1  currently committed mode.

Behaviour:
- Reset (async, rst=1): counter, all shadow/active codes, accumulators, dac_out, pending, period_tick, mode_active and mode shadow clear to 0.
- Counter: WIDTH bits; increments by 1 each cycle en=1; wraps 2^WIDTH-1 -> 0; holds when en=0.
- Commit event: en=1 and counter == 2^WIDTH-1.
  - In that cycle: active[i] <= shadow[i] for all i, mode_active <= mode shadow, pending <= 0, period_tick <= 1 (next cycle).
  - New values govern outputs from counter = 0 onward.
- Writes:
  - wr_en=1 with wr_ch < CHANNELS: shadow[wr_ch] <= wr_data and pending[wr_ch] <= 1.
  - wr_ch >= CHANNELS: write ignored, no state change.
  - Writes are accepted regardless of en.
- Mode shadow: loaded from mode_in every cycle; only the value present at the commit edge is committed.
- Write coinciding with commit:
  - Commit takes the pre-write shadow value.
  - The written channel's shadow takes wr_data and its pending bit stays 1.
  - The new value commits at the next boundary.
- PWM mode, registered (1-cycle latency from the counter):
  - dac_out[i] <= (counter < active[i]).
  - Code 0 gives a constant 0.
  - Code 2^WIDTH-1 gives high for 2^WIDTH-1 of every 2^WIDTH cycles.
- Sigma-delta mode:
  - Per-channel accumulator acc[i], WIDTH bits.
  - Each en cycle: {carry, acc[i]} <= acc[i] + active[i]; dac_out[i] <= carry.
  - Over any 2^WIDTH consecutive en cycles with a constant code, the count of ones equals the code exactly.
- Mode switch at commit: accumulators clear to 0 on every commit where mode_active changes, so the first period in the new mode is deterministic.
- en=0: dac_out forced to 0 on the next edge; counter, accumulators and active codes hold; period_tick stays 0. On re-enable, operation resumes from the held counter and accumulator values.
- rst asserted mid-period: everything returns to reset values immediately (asynchronous); pending writes are lost.
- period_tick: high exactly one cycle, the cycle after each commit edge, i.e. while counter = 0.

Test Plan (WIDTH=4, CHANNELS=2 unless stated):
- Reset and idle: rst pulse, then en=1 with no writes for 32 cycles -> dac_out=00, pending=00, period_tick high at cycles 16 and 32 after en.
- PWM duty: write ch0=5, ch1=15, mode_in=0, run 3 periods -> from the second period, ch0 high 5 of 16 cycles at counter 0..4 (+1 cycle latency); ch1 high 15 of 16; pending cleared at the commit.
- Sigma-delta density: mode_in=1, ch0=3 -> after the commit, every 16-cycle window contains exactly 3 ones, no two adjacent; ch1=8 toggles 1010.
- Write on commit edge: write ch0=7 in the cycle counter=15 while the shadow holds 2 -> the next period uses 2, pending[0] stays 1, the following period uses 7.
- Invalid channel and enable gating: wr_ch=5 -> no pending change. Drop en for 10 cycles mid-period -> dac_out 0, counter frozen, remaining duty completes after re-enable.
- Async reset mid-period (WIDTH=12, CHANNELS=4): assert rst between clock edges at counter=1000 -> all outputs 0 before the next edge, counter restarts at 0.
